// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Power-up instruction memory loader. Receives a byte stream, a 4-byte
//   little-endian length header N (in words) followed by N little-endian
//   32-bit words. Each word is written into instruction memory. The core is
//   held in stall until the whole program has been loaded. After that, the
//   memory address port is handed to the core fetch PC.
//
//   Optional feature, selected by the macro IMEM_LOAD_CSUM_EN:
//     When defined, a 4-byte little-endian trailer follows the last word.
//     It must equal the mod-2^32 sum of all written words. A match goes to
//     DONE. A mismatch goes to ERR, and the memory is not rolled back.
//     When undefined, there is no CSUM state and no sum register.
//
// Parameters:
//   DEPTH_WORDS  instruction memory depth in words (maximum program length)
//   CNT_W        width of the word counter and the stored length
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse; begins a (re)load from IDLE/DONE/ERR
//   rx_data    stream byte
//   rx_valid   rx_data valid
//   rx_ready   loader accepts a byte (transfer on rx_valid && rx_ready)
//   cpu_pc     core fetch byte address
//   mem_addr   byte address to instruction memory (cpu_pc once loaded)
//   mem_we     write strobe, one cycle per word
//   mem_wdata  assembled word
//   cpu_stall  1 = core must not fetch/advance
//   load_done  program loaded, core running
//   load_err   load aborted
module imem_boot_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] cpu_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    WRITE,
    DONE,
`ifdef IMEM_LOAD_CSUM_EN
    CSUM,
`endif
    ERR
  } state_t;

  state_t           state;
  logic [23:0]      hdr;       // first three bytes of a header/trailer, LSB first
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] len;
`ifdef IMEM_LOAD_CSUM_EN
  logic [31:0]      sum;
`endif

  logic        accept;
  logic [31:0] hdr_full;
  logic        len_bad;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  // The 4th byte is still on rx_data, so the complete value is formed here.
  assign hdr_full  = {rx_data, hdr};
  assign len_bad   = (hdr_full == 32'd0) ||
                     (hdr_full > 32'(DEPTH_WORDS)) ||
                     ((hdr_full >> CNT_W) != 32'd0);
  assign last_word = (word_idx == len - CNT_W'(1));

  // Only the address is combinational, so fetch sees memory with zero latency.
  assign mem_addr  = (state == DONE) ? cpu_pc : (32'(word_idx) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdr       <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      len       <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_stall <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= HDR;
            rx_ready  <= 1'b1;
            cpu_stall <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            byte_idx  <= '0;
`ifdef IMEM_LOAD_CSUM_EN
            sum       <= '0;
`endif
          end
        end

        HDR: begin
          if (accept) begin
            hdr      <= {rx_data, hdr[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (len_bad) begin
                state    <= ERR;
                rx_ready <= 1'b0;
                load_err <= 1'b1;
              end else begin
                state    <= LOAD;
                len      <= hdr_full[CNT_W-1:0];
                word_idx <= '0;
                byte_idx <= '0;
              end
            end
          end
        end

        LOAD: begin
          if (accept) begin
            mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state    <= WRITE;
              rx_ready <= 1'b0;
              mem_we   <= 1'b1;
            end
          end
        end

        WRITE: begin
`ifdef IMEM_LOAD_CSUM_EN
          sum <= sum + mem_wdata;
`endif
          if (last_word) begin
`ifdef IMEM_LOAD_CSUM_EN
            state     <= CSUM;
            rx_ready  <= 1'b1;
`else
            state     <= DONE;
            cpu_stall <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            state    <= LOAD;
            rx_ready <= 1'b1;
            word_idx <= word_idx + CNT_W'(1);
          end
        end

`ifdef IMEM_LOAD_CSUM_EN
        CSUM: begin
          if (accept) begin
            hdr      <= {rx_data, hdr[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              rx_ready <= 1'b0;
              if (hdr_full == sum) begin
                state     <= DONE;
                cpu_stall <= 1'b0;
                load_done <= 1'b1;
              end else begin
                state    <= ERR;
                load_err <= 1'b1;
              end
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
